clock_phase_seq: RTL

- Parametrised successor to the two-phase CPU clock generator.
- Produces NUM_PHASES non-overlapping, one-hot phase enables from the single clock `clkin`.
- Divide ratio is runtime-programmable; the phase gap is configurable.
- Adds run/halt and single-step control so the tiny16 core can be frozen and stepped for debug. Halts happen only on whole-cycle boundaries.
- All outputs are registered on posedge `clkin`; no derived-clock or negedge logic.

---
 rtl/clock_phase_seq.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/clock_phase_seq.sv
// Non-overlapping one-hot phase sequencer with a programmable divide, run/halt/single-step control and a machine-cycle counter.
// Outputs are registered on clkin; a run or step request shows up as phase[0] one cycle later. Halts take effect only at machine-cycle boundaries.
module clock_phase_seq #(
    parameter int NUM_PHASES = 2,
    parameter int DIV_W      = 8,
    parameter int RESET_DIV  = 0,
    parameter int GAP        = 0,
    parameter int CNT_W      = 16
) (
    input  logic                          clkin,
    input  logic                          rst_n,
    input  logic [DIV_W-1:0]              div_in,
    input  logic                          div_load,
    input  logic                          run,
    input  logic                          step,
    output logic [NUM_PHASES-1:0]         phase,
    output logic [$clog2(NUM_PHASES)-1:0] phase_idx,
    output logic                          phase_start,
    output logic                          cycle_done,
    output logic                          halted,
    output logic [CNT_W-1:0]              cycle_count
);

    localparam int IW = $clog2(NUM_PHASES);
    localparam int PW = (DIV_W > 4) ? DIV_W : 4;
    localparam logic [IW-1:0]    LAST_IDX = IW'(NUM_PHASES - 1);
    localparam logic [PW-1:0]    GAP_LAST = (GAP > 0) ? PW'(GAP - 1) : '0;
    localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(RESET_DIV);

    typedef enum logic [1:0] {
        S_HALTED,
        S_RUN,
        S_STEP,
        S_DRAIN
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [PW-1:0]     presc;
    logic [PW-1:0]     presc_n;
    logic              in_gap;
    logic              gap_n;
    logic [DIV_W-1:0]  div_act;
    logic [DIV_W-1:0]  div_n;
    logic [DIV_W-1:0]  div_shadow;
    logic [DIV_W-1:0]  shadow_n;
    logic [IW-1:0]     idx_n;
    logic [IW-1:0]     idx_inc;
    logic [NUM_PHASES-1:0] phase_n;
    logic              start_n;
    logic              done_n;
    logic              halted_n;
    logic [CNT_W-1:0]  count_n;
    logic              phase_end;
    logic              gap_end;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_HALTED;
        end else begin
            state <= state_n;
        end
    end

    // A drop of run at the cycle_done edge halts directly; DRAIN only covers mid-cycle drops.
    always_comb begin
        state_n = state;
        case (state)
            S_HALTED: begin
                if (run) begin
                    state_n = S_RUN;
                end else if (step) begin
                    state_n = S_STEP;
                end
            end
            S_RUN: begin
                if (cycle_done) begin
                    state_n = run ? S_RUN : S_HALTED;
                end else if (!run) begin
                    state_n = S_DRAIN;
                end
            end
            S_STEP: begin
                if (cycle_done) begin
                    state_n = S_HALTED;
                end
            end
            S_DRAIN: begin
                if (cycle_done) begin
                    state_n = S_HALTED;
                end else if (run) begin
                    state_n = S_RUN;
                end
            end
            default: state_n = S_HALTED;
        endcase
    end

    always_comb begin
        shadow_n = div_load ? div_in : div_shadow;
        div_n    = div_act;
        // A load landing on the same edge as the copy takes effect for the new cycle.
        if (state == S_HALTED || cycle_done) begin
            div_n = shadow_n;
        end

        phase_end = !in_gap && (presc == PW'(div_act));
        gap_end   = in_gap && (presc == GAP_LAST);
        idx_inc   = (phase_idx == LAST_IDX) ? '0 : phase_idx + 1'b1;

        presc_n = '0;
        gap_n   = 1'b0;
        idx_n   = phase_idx;
        if (state_n == S_HALTED) begin
            idx_n = phase_idx;
        end else if (state == S_HALTED) begin
            idx_n = '0;
        end else if (gap_end || (phase_end && GAP == 0)) begin
            idx_n = idx_inc;
        end else if (phase_end) begin
            gap_n = 1'b1;
        end else begin
            presc_n = presc + 1'b1;
            gap_n   = in_gap;
        end

        phase_n = '0;
        if (state_n != S_HALTED && !gap_n) begin
            phase_n[idx_n] = 1'b1;
        end
        start_n = (state_n != S_HALTED) && !gap_n && (presc_n == '0);
        if (GAP == 0) begin
            done_n = (state_n != S_HALTED) && (idx_n == LAST_IDX) && !gap_n &&
                     (presc_n == PW'(div_n));
        end else begin
            done_n = (state_n != S_HALTED) && (idx_n == LAST_IDX) && gap_n &&
                     (presc_n == GAP_LAST);
        end
        halted_n = (state_n == S_HALTED);
        count_n  = cycle_done ? cycle_count + 1'b1 : cycle_count;
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            presc       <= '0;
            in_gap      <= 1'b0;
            div_act     <= DIV_RST;
            div_shadow  <= DIV_RST;
            phase       <= '0;
            phase_idx   <= '0;
            phase_start <= 1'b0;
            cycle_done  <= 1'b0;
            halted      <= 1'b1;
            cycle_count <= '0;
        end else begin
            presc       <= presc_n;
            in_gap      <= gap_n;
            div_act     <= div_n;
            div_shadow  <= shadow_n;
            phase       <= phase_n;
            phase_idx   <= idx_n;
            phase_start <= start_n;
            cycle_done  <= done_n;
            halted      <= halted_n;
            cycle_count <= count_n;
        end
    end

    onehot_phase: assert property (@(posedge clkin) disable iff (!rst_n) $onehot0(phase));

endmodule
